// File: rtl/cdc_event_mux_pkg.sv
// Shared types and helpers for the multi-source event crossing.
package cdc_event_mux_pkg;

    localparam int MAX_N = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_SEND = 3'b010,
        ST_WAIT = 3'b100
    } a_state_e;

    // Round-robin search starting just after 'last'; returns 0 when nothing is pending.
    function automatic int rr_pick(input logic [MAX_N-1:0] pending, input int last, input int n);
        int  win;
        int  idx;
        logic found;
        win   = 0;
        found = 1'b0;
        for (int k = 1; k <= MAX_N; k++) begin
            if (k <= n) begin
                idx = (last + k) % n;
                if (!found && pending[idx]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/cdc_pulse_sync.sv
// Single-pulse crossing built on a toggle request and a synchronized acknowledge.
module cdc_pulse_sync (
    input  logic src_clk,
    input  logic src_reset,
    input  logic pulse_in,
    output logic src_error,
    input  logic dst_clk,
    input  logic dst_reset,
    output logic pulse_out,
    output logic dst_error
);

    // Handshake: a pulse_in flips req_tog; the destination flags each change of
    // its synchronized copy as one pulse_out and returns that copy as ack. The
    // source is busy while req_tog and the returned ack differ; a pulse_in that
    // arrives while busy is dropped and reported on src_error.
    logic req_tog;
    logic ack_s1;
    logic ack_s2;
    logic busy;
    logic req_s1;
    logic req_s2;
    logic req_s3;
    logic edge_q;

    assign busy      = req_tog ^ ack_s2;
    assign pulse_out = req_s2 ^ req_s3;

    always_ff @(posedge src_clk) begin
        if (src_reset) begin
            req_tog   <= 1'b0;
            ack_s1    <= 1'b0;
            ack_s2    <= 1'b0;
            src_error <= 1'b0;
        end else begin
            ack_s1    <= req_s2;
            ack_s2    <= ack_s1;
            src_error <= pulse_in && busy;
            if (pulse_in && !busy) begin
                req_tog <= ~req_tog;
            end
        end
    end

    // A legal source cannot change the request on two consecutive destination edges.
    always_ff @(posedge dst_clk) begin
        if (dst_reset) begin
            req_s1    <= 1'b0;
            req_s2    <= 1'b0;
            req_s3    <= 1'b0;
            edge_q    <= 1'b0;
            dst_error <= 1'b0;
        end else begin
            req_s1    <= req_tog;
            req_s2    <= req_s1;
            req_s3    <= req_s2;
            edge_q    <= pulse_out;
            dst_error <= pulse_out && edge_q;
        end
    end

endmodule

// File: rtl/cdc_event_mux.sv
// Latches N event strobes, arbitrates them round-robin and carries them one at a
// time from a_clk to b_clk over a shared pulse crossing plus a quasi-static index.
module cdc_event_mux
    import cdc_event_mux_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         a_clk,
    input  logic         a_reset,
    input  logic [N-1:0] a_event,
    output logic [N-1:0] a_pending,
    output logic [N-1:0] a_overflow,
    output logic         a_busy,
    output logic         a_error,
    output a_state_e     a_state,
    input  logic         b_clk,
    input  logic         b_reset,
    output logic [N-1:0] b_event,
    output logic         b_error
);

    localparam int IW = $clog2(N);

    a_state_e            state_q;
    a_state_e            state_d;
    logic [IW-1:0]       a_sel;
    logic [IW-1:0]       last_q;
    logic [IW-1:0]       winner;
    logic [MAX_N-1:0]    pend_wide;
    logic [N-1:0]        grant_mask;
    logic [N-1:0]        pending_d;
    logic [N-1:0]        overflow_d;
    logic [N-1:0]        b_event_d;
    logic                grant;
    logic                fwd_pulse;
    logic                done;
    logic                b_pulse_out;
    logic                fwd_src_err;
    logic                fwd_dst_err;
    logic                ret_src_err;
    logic                ret_dst_err;

    assign grant     = (state_q == ST_IDLE) && (|a_pending);
    assign fwd_pulse = (state_q == ST_SEND);
    assign a_busy    = (state_q != ST_IDLE);
    assign a_state   = state_q;

    always_comb begin
        pend_wide           = '0;
        pend_wide[N-1:0]    = a_pending;
        winner              = IW'(rr_pick(pend_wide, int'(last_q), N));
        grant_mask          = '0;
        if (grant) begin
            grant_mask[winner] = 1'b1;
        end
        // An event coinciding with its own grant re-arms the bit without counting as overflow.
        pending_d  = a_event | (a_pending & ~grant_mask);
        overflow_d = a_overflow | (a_event & a_pending & ~grant_mask);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant) state_d = ST_SEND;
            ST_SEND: state_d = ST_WAIT;
            ST_WAIT: if (done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge a_clk) begin
        if (a_reset) begin
            state_q    <= ST_IDLE;
            a_pending  <= '0;
            a_overflow <= '0;
            a_sel      <= '0;
            last_q     <= IW'(N - 1);
            a_error    <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_pending  <= pending_d;
            a_overflow <= overflow_d;
            if (grant) begin
                a_sel  <= winner;
                last_q <= winner;
            end
            a_error <= a_error | fwd_src_err | ret_dst_err | (done && (state_q != ST_WAIT));
        end
    end

    cdc_pulse_sync u_fwd_sync (
        .src_clk   (a_clk),
        .src_reset (a_reset),
        .pulse_in  (fwd_pulse),
        .src_error (fwd_src_err),
        .dst_clk   (b_clk),
        .dst_reset (b_reset),
        .pulse_out (b_pulse_out),
        .dst_error (fwd_dst_err)
    );

    cdc_pulse_sync u_ret_sync (
        .src_clk   (b_clk),
        .src_reset (b_reset),
        .pulse_in  (b_pulse_out),
        .src_error (ret_src_err),
        .dst_clk   (a_clk),
        .dst_reset (a_reset),
        .pulse_out (done),
        .dst_error (ret_dst_err)
    );

    // a_sel has been stable since the grant, well before the forward pulse lands here.
    always_comb begin
        b_event_d = '0;
        if (b_pulse_out) begin
            b_event_d[a_sel] = 1'b1;
        end
    end

    always_ff @(posedge b_clk) begin
        if (b_reset) begin
            b_event <= '0;
            b_error <= 1'b0;
        end else begin
            b_event <= b_event_d;
            b_error <= b_error | fwd_dst_err | ret_src_err;
        end
    end

endmodule
